// File: rtl/ethernet_rx_mmio_reader_if.sv
// Bus bundle between the rx MMIO reader and its neighbours: the MMIO
// initiator port toward the ethernet controller plus the AXI-Stream
// master port toward the packet sink. The master modport is the reader's
// view; the slave modport is the controller/sink view.
interface ethernet_rx_mmio_reader_if #(
    parameter int axis_width_p = 64
);
    logic [15:0]               mmio_addr_o;
    logic                      mmio_write_en_o;
    logic                      mmio_read_en_o;
    logic [1:0]                mmio_op_size_o;
    logic [axis_width_p-1:0]   mmio_write_data_o;
    logic [axis_width_p-1:0]   mmio_read_data_i;
    logic                      mmio_read_data_v_i;

    logic [axis_width_p-1:0]   m_axis_tdata_o;
    logic [axis_width_p/8-1:0] m_axis_tkeep_o;
    logic                      m_axis_tlast_o;
    logic                      m_axis_tvalid_o;
    logic                      m_axis_tready_i;

    modport master (
        output mmio_addr_o,
        output mmio_write_en_o,
        output mmio_read_en_o,
        output mmio_op_size_o,
        output mmio_write_data_o,
        input  mmio_read_data_i,
        input  mmio_read_data_v_i,
        output m_axis_tdata_o,
        output m_axis_tkeep_o,
        output m_axis_tlast_o,
        output m_axis_tvalid_o,
        input  m_axis_tready_i
    );

    modport slave (
        input  mmio_addr_o,
        input  mmio_write_en_o,
        input  mmio_read_en_o,
        input  mmio_op_size_o,
        input  mmio_write_data_o,
        output mmio_read_data_i,
        output mmio_read_data_v_i,
        input  m_axis_tdata_o,
        input  m_axis_tkeep_o,
        input  m_axis_tlast_o,
        input  m_axis_tvalid_o,
        output m_axis_tready_i
    );
endinterface

// File: rtl/ethernet_rx_mmio_reader.sv
// Host-side MMIO initiator that drains received frames from the ethernet
// controller. After reset it enables the rx interrupt once, then for every
// pending frame it reads the frame size, fetches the frame one beat per
// MMIO read, hands each beat out on AXI-Stream and finally writes the
// clear-buffer register. Bad sizes (zero or larger than the controller
// buffer) skip the data phase, pulse drop_o and still clear the buffer.
// Only one MMIO read is ever outstanding; read-valid outside a wait state
// is ignored.
module ethernet_rx_mmio_reader #(
    parameter int          buf_size_p      = 2048,
    parameter int          axis_width_p    = 64,
    parameter logic [15:0] rx_en_addr_p    = 16'h1018,
    parameter logic [15:0] rx_size_addr_p  = 16'h1004,
    parameter logic [15:0] rx_clear_addr_p = 16'h1000,
    parameter logic [15:0] rx_buf_base_p   = 16'h0000
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic rx_interrupt_pending_i,
    output logic drop_o,
    ethernet_rx_mmio_reader_if.master bus
);

    localparam int                      BEAT_BYTES = axis_width_p / 8;
    localparam logic [15:0]             BEAT_W     = 16'(BEAT_BYTES);
    localparam logic [15:0]             BUF_W      = 16'(buf_size_p);
    localparam logic [1:0]              DATA_OP    = 2'($clog2(BEAT_BYTES));
    localparam logic [1:0]              REG_OP     = 2'd2;
    localparam logic [axis_width_p-1:0] ONE_WORD   = axis_width_p'(1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD_SIZE,
        S_W_SIZE,
        S_RD_DATA,
        S_W_DATA,
        S_SEND,
        S_CLEAR
    } state_t;

    state_t                  r_state;
    logic [15:0]             r_rem;
    logic [15:0]             r_bufAddr;
    logic [15:0]             r_mmioAddr;
    logic                    r_writeEn;
    logic                    r_readEn;
    logic [1:0]              r_opSize;
    logic [axis_width_p-1:0] r_writeData;
    logic [axis_width_p-1:0] r_tdata;
    logic [BEAT_BYTES-1:0]   r_tkeep;
    logic                    r_tlast;
    logic                    r_tvalid;
    logic                    r_drop;

    logic [BEAT_BYTES-1:0]   w_keep;
    logic                    w_lastBeat;
    logic [15:0]             w_remNext;
    logic [15:0]             w_rdSize;
    logic                    w_sizeBad;

    assign w_lastBeat = (r_rem <= BEAT_W);
    assign w_remNext  = w_lastBeat ? 16'd0 : (r_rem - BEAT_W);
    assign w_rdSize   = bus.mmio_read_data_i[15:0];
    assign w_sizeBad  = (w_rdSize == 16'd0) || (w_rdSize > BUF_W);

    // Byte enables for the beat being fetched: one bit per byte still owed.
    always_comb begin
        w_keep = '0;
        for (int b = 0; b < BEAT_BYTES; b++) begin
            w_keep[b] = (r_rem > 16'(b));
        end
    end

    // Frame-draining sequencer; every bus-facing output is registered here.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= S_INIT;
            r_rem       <= '0;
            r_bufAddr   <= '0;
            r_mmioAddr  <= '0;
            r_writeEn   <= 1'b0;
            r_readEn    <= 1'b0;
            r_opSize    <= '0;
            r_writeData <= '0;
            r_tdata     <= '0;
            r_tkeep     <= '0;
            r_tlast     <= 1'b0;
            r_tvalid    <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_writeEn <= 1'b0;
            r_readEn  <= 1'b0;
            r_drop    <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_mmioAddr  <= rx_en_addr_p;
                    r_opSize    <= REG_OP;
                    r_writeData <= ONE_WORD;
                    r_writeEn   <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_IDLE: begin
                    if (rx_interrupt_pending_i) begin
                        r_state <= S_RD_SIZE;
                    end
                end
                S_RD_SIZE: begin
                    r_mmioAddr <= rx_size_addr_p;
                    r_opSize   <= REG_OP;
                    r_readEn   <= 1'b1;
                    r_state    <= S_W_SIZE;
                end
                S_W_SIZE: begin
                    if (bus.mmio_read_data_v_i) begin
                        if (w_sizeBad) begin
                            r_drop  <= 1'b1;
                            r_state <= S_CLEAR;
                        end else begin
                            r_rem     <= w_rdSize;
                            r_bufAddr <= rx_buf_base_p;
                            r_state   <= S_RD_DATA;
                        end
                    end
                end
                S_RD_DATA: begin
                    r_mmioAddr <= r_bufAddr;
                    r_opSize   <= DATA_OP;
                    r_readEn   <= 1'b1;
                    r_state    <= S_W_DATA;
                end
                S_W_DATA: begin
                    if (bus.mmio_read_data_v_i) begin
                        r_tdata  <= bus.mmio_read_data_i;
                        r_tkeep  <= w_lastBeat ? w_keep : '1;
                        r_tlast  <= w_lastBeat;
                        r_tvalid <= 1'b1;
                        r_state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (bus.m_axis_tready_i) begin
                        r_tvalid  <= 1'b0;
                        r_bufAddr <= r_bufAddr + BEAT_W;
                        r_rem     <= w_remNext;
                        r_state   <= w_lastBeat ? S_CLEAR : S_RD_DATA;
                    end
                end
                S_CLEAR: begin
                    r_mmioAddr  <= rx_clear_addr_p;
                    r_opSize    <= REG_OP;
                    r_writeData <= ONE_WORD;
                    r_writeEn   <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    assign bus.mmio_addr_o       = r_mmioAddr;
    assign bus.mmio_write_en_o   = r_writeEn;
    assign bus.mmio_read_en_o    = r_readEn;
    assign bus.mmio_op_size_o    = r_opSize;
    assign bus.mmio_write_data_o = r_writeData;
    assign bus.m_axis_tdata_o    = r_tdata;
    assign bus.m_axis_tkeep_o    = r_tkeep;
    assign bus.m_axis_tlast_o    = r_tlast;
    assign bus.m_axis_tvalid_o   = r_tvalid;
    assign drop_o                = r_drop;

endmodule
